// File: rtl/obi_data_if.sv
// OBI-style data port bundle (req/gnt address phase, rvalid response phase).
// Address phase: the master holds req/addr/we/be/wdata stable until it sees gnt,
// and the transfer is accepted on the rising edge where req & gnt are both high.
// Response phase: rvalid pulses for one cycle per transaction, in order, and
// cannot be back-pressured. rdata/err are meaningful only while rvalid is high.
interface obi_data_if;
   logic        req;
   logic        gnt;
   logic [31:0] addr;
   logic        we;
   logic [3:0]  be;
   logic [31:0] wdata;
   logic        rvalid;
   logic [31:0] rdata;
   logic        err;

   modport master (
      output req, addr, we, be, wdata,
      input  gnt, rvalid, rdata, err
   );

   modport slave (
      input  req, addr, we, be, wdata,
      output gnt, rvalid, rdata, err
   );
endinterface

// File: rtl/obi_data_responder.sv
// Word-addressed RAM behind an OBI data port, with stallable grants and an
// in-order response FIFO that enforces a minimum accept-to-rvalid latency.
module obi_data_responder #(
   parameter int ADDR_WIDTH      = 12,
   parameter int MAX_OUTSTANDING = 4,
   parameter int RSP_LATENCY     = 1,
   parameter int CNT_WIDTH       = 8
) (
   input  logic                                 clk_i,
   input  logic                                 rst_ni,
   obi_data_if.slave                            data,
   input  logic                                 gnt_stall_i,
   input  logic                                 rsp_stall_i,
   output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o
);

   localparam int OCC_W = $clog2(MAX_OUTSTANDING + 1);
   localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int DEPTH = 2 ** ADDR_WIDTH;

   logic [31:0]           mem        [DEPTH];
   logic [31:0]           fifo_rdata [MAX_OUTSTANDING];
   logic                  fifo_err   [MAX_OUTSTANDING];
   logic [CNT_WIDTH-1:0]  fifo_stamp [MAX_OUTSTANDING];

   logic [PTR_W-1:0]      wr_ptr, rd_ptr;
   logic [OCC_W-1:0]      count;
   logic [CNT_WIDTH-1:0]  cyc_cnt;
   logic [CNT_WIDTH-1:0]  head_age;
   logic [ADDR_WIDTH-1:0] word_idx;
   logic                  in_range;
   logic                  gnt;
   logic                  accept;
   logic                  pop;
   logic [31:0]           push_rdata;
   logic                  rvalid_q;
   logic [31:0]           rdata_q;
   logic                  err_q;
   logic                  unused_addr_bits;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
   endfunction

   assign word_idx         = data.addr[ADDR_WIDTH+1:2];
   assign in_range         = (data.addr[31:ADDR_WIDTH+2] == '0);
   assign unused_addr_bits = ^data.addr[1:0];

   // No bypass: a full FIFO refuses the grant even if it pops this cycle.
   assign gnt    = data.req & ~gnt_stall_i & (count < OCC_W'(MAX_OUTSTANDING));
   assign accept = data.req & gnt;

   // Loads snapshot the word now, so later stores cannot leak into them.
   assign push_rdata = (in_range & ~data.we) ? mem[word_idx] : '0;

   // Modulo subtraction keeps the age correct across counter wrap.
   assign head_age = cyc_cnt - fifo_stamp[rd_ptr];
   assign pop      = (count != '0) & ~rsp_stall_i & (head_age >= CNT_WIDTH'(RSP_LATENCY));

   always_ff @(posedge clk_i) begin
      if (accept & data.we & in_range) begin
         for (int k = 0; k < 4; k++) begin
            if (data.be[k]) mem[word_idx][8*k +: 8] <= data.wdata[8*k +: 8];
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (accept) begin
         fifo_rdata[wr_ptr] <= push_rdata;
         fifo_err[wr_ptr]   <= ~in_range;
         fifo_stamp[wr_ptr] <= cyc_cnt;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cyc_cnt  <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         cyc_cnt  <= cyc_cnt + 1'b1;
         rvalid_q <= pop;
         if (accept) wr_ptr <= next_ptr(wr_ptr);
         if (pop) begin
            rd_ptr  <= next_ptr(rd_ptr);
            rdata_q <= fifo_rdata[rd_ptr];
            err_q   <= fifo_err[rd_ptr];
         end
         case ({accept, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign data.gnt      = gnt;
   assign data.rvalid   = rvalid_q;
   assign data.rdata    = rdata_q;
   assign data.err      = err_q;
   assign outstanding_o = count;

endmodule

// File: tb/tb_obi_data_responder.sv
// Directed bench for obi_data_responder: vector table on a latency-1 instance,
// plus hand sequences for FIFO-full, grant stall (latency-3 instance) and reset.
module tb_obi_data_responder;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       gnt_stall = 1'b0, rsp_stall = 1'b0;
   logic       gnt_stall3 = 1'b0, rsp_stall3 = 1'b0;
   logic [2:0] outstanding, outstanding3;

   obi_data_if bus ();
   obi_data_if bus3 ();

   obi_data_responder #(.ADDR_WIDTH(12), .MAX_OUTSTANDING(4), .RSP_LATENCY(1), .CNT_WIDTH(8)) dut (
      .clk_i(clk), .rst_ni(rst_n), .data(bus.slave),
      .gnt_stall_i(gnt_stall), .rsp_stall_i(rsp_stall), .outstanding_o(outstanding)
   );

   obi_data_responder #(.ADDR_WIDTH(12), .MAX_OUTSTANDING(4), .RSP_LATENCY(3), .CNT_WIDTH(8)) dut3 (
      .clk_i(clk), .rst_ni(rst_n), .data(bus3.slave),
      .gnt_stall_i(gnt_stall3), .rsp_stall_i(rsp_stall3), .outstanding_o(outstanding3)
   );

   // ---------------- clock / cycle count ----------------
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- response monitor (latency-1 instance) ----------------
   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          cyc;
   } rsp_t;

   rsp_t rsp_log [256];
   int   rsp_wr = 0;

   always @(negedge clk) begin
      if (bus.rvalid === 1'b1 && rsp_wr < 256) begin
         rsp_log[rsp_wr] = '{bus.rdata, bus.err, cyc};
         rsp_wr = rsp_wr + 1;
      end
   end

   // ---------------- scoreboard ----------------
   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          acc;
      bit          chk_lat;
      bit          chk_b2b;
   } exp_t;

   exp_t exp_q [$];
   int   rsp_rd = 0;
   int   prev_rsp_cyc = 0;
   int   checks = 0;
   int   errors = 0;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic        err;
   } vec_t;

   vec_t vecs [18];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic issue(input logic we, input logic [31:0] addr, input logic [3:0] be,
                        input logic [31:0] wdata, input logic [31:0] exp_rdata, input logic exp_err,
                        input bit push, input bit chk_lat, input bit chk_b2b, output int acc);
      int n;
      n   = 0;
      acc = -1;
      bus.req   = 1'b1;
      bus.we    = we;
      bus.addr  = addr;
      bus.be    = be;
      bus.wdata = wdata;
      @(negedge clk);
      while (bus.gnt !== 1'b1 && n < 50) begin
         n++;
         @(negedge clk);
      end
      checks++;
      if (bus.gnt !== 1'b1) begin
         errors++;
         $display("FAIL grant_timeout: addr %h got gnt %b expected 1 within 50 cycles", addr, bus.gnt);
      end else begin
         acc = cyc + 1;
         if (push) exp_q.push_back('{exp_rdata, exp_err, acc, chk_lat, chk_b2b});
      end
      @(posedge clk);
      #1;
      bus.req = 1'b0;
   endtask

   task automatic txn3(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input int stall);
      int acc, n, rv_cyc;
      gnt_stall3 = (stall > 0);
      bus3.req   = 1'b1;
      bus3.we    = we;
      bus3.addr  = addr;
      bus3.be    = 4'hF;
      bus3.wdata = wdata;
      for (int i = 0; i < stall; i++) begin
         @(negedge clk);
         check("gnt_while_stalled", bus3.gnt, 1'b0);
      end
      if (stall > 0) begin
         @(posedge clk);
         #1;
         gnt_stall3 = 1'b0;
      end
      @(negedge clk);
      check("gnt_after_stall", bus3.gnt, 1'b1);
      acc = cyc + 1;
      @(posedge clk);
      #1;
      bus3.req = 1'b0;
      n = 0;
      rv_cyc = -1;
      while (n < 20 && rv_cyc < 0) begin
         @(negedge clk);
         if (bus3.rvalid === 1'b1) rv_cyc = cyc;
         n++;
      end
      check("latency3", rv_cyc - acc, 3);
      check("rdata3", bus3.rdata, exp_rdata);
      check("err3", bus3.err, 1'b0);
      @(negedge clk);
      check("single_rvalid3", bus3.rvalid, 1'b0);
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      exp_t e;
      rsp_t r;
      repeat (8) @(posedge clk);
      #1;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (rsp_rd >= rsp_wr) begin
            checks++;
            errors++;
            $display("FAIL missing_rsp: got none expected rdata %h err %b", e.rdata, e.err);
         end else begin
            r = rsp_log[rsp_rd];
            rsp_rd++;
            check("rdata", r.rdata, e.rdata);
            check("err", r.err, e.err);
            if (e.chk_lat) check("latency", r.cyc - e.acc, 1);
            if (e.chk_b2b) check("back_to_back", r.cyc - prev_rsp_cyc, 1);
            prev_rsp_cyc = r.cyc;
         end
      end
      while (rsp_rd < rsp_wr) begin
         checks++;
         errors++;
         $display("FAIL extra_rsp: got rdata %h err %b expected no response",
                  rsp_log[rsp_rd].rdata, rsp_log[rsp_rd].err);
         rsp_rd++;
      end
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   // ---------------- test sequence ----------------
   initial begin
      int acc;
      int rel;
      int wr_at_reset;

      vecs[0]  = '{1'b1, 32'h0000_0100, 4'hF, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
      vecs[1]  = '{1'b0, 32'h0000_0100, 4'hF, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0};
      vecs[2]  = '{1'b1, 32'h0000_0100, 4'h1, 32'h0000_00AA, 32'h0000_0000, 1'b0};
      vecs[3]  = '{1'b0, 32'h0000_0100, 4'hF, 32'h0000_0000, 32'hDEAD_BEAA, 1'b0};
      vecs[4]  = '{1'b0, 32'h0000_0102, 4'hF, 32'h0000_0000, 32'hDEAD_BEAA, 1'b0};
      vecs[5]  = '{1'b0, 32'h0000_0100, 4'h0, 32'h0000_0000, 32'hDEAD_BEAA, 1'b0};
      vecs[6]  = '{1'b1, 32'h0000_0200, 4'hF, 32'hCAFE_F00D, 32'h0000_0000, 1'b0};
      vecs[7]  = '{1'b1, 32'h0000_0200, 4'h6, 32'h1122_3344, 32'h0000_0000, 1'b0};
      vecs[8]  = '{1'b0, 32'h0000_0200, 4'hF, 32'h0000_0000, 32'hCA22_330D, 1'b0};
      vecs[9]  = '{1'b1, 32'h0000_0204, 4'hF, 32'h5555_5555, 32'h0000_0000, 1'b0};
      vecs[10] = '{1'b1, 32'h0000_0204, 4'h0, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0};
      vecs[11] = '{1'b0, 32'h0000_0204, 4'hF, 32'h0000_0000, 32'h5555_5555, 1'b0};
      vecs[12] = '{1'b0, 32'h0000_4000, 4'hF, 32'h0000_0000, 32'h0000_0000, 1'b1};
      vecs[13] = '{1'b1, 32'h0000_4100, 4'hF, 32'h9999_9999, 32'h0000_0000, 1'b1};
      vecs[14] = '{1'b0, 32'h0000_0100, 4'hF, 32'h0000_0000, 32'hDEAD_BEAA, 1'b0};
      vecs[15] = '{1'b1, 32'h0000_3FFC, 4'hF, 32'h0BAD_CAFE, 32'h0000_0000, 1'b0};
      vecs[16] = '{1'b0, 32'h0000_3FFF, 4'hF, 32'h0000_0000, 32'h0BAD_CAFE, 1'b0};
      vecs[17] = '{1'b0, 32'hFFFF_FFFC, 4'hF, 32'h0000_0000, 32'h0000_0000, 1'b1};

      bus.req  = 1'b0; bus.we  = 1'b0; bus.addr  = '0; bus.be  = '0; bus.wdata  = '0;
      bus3.req = 1'b0; bus3.we = 1'b0; bus3.addr = '0; bus3.be = '0; bus3.wdata = '0;

      // reset
      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_rvalid", bus.rvalid, 1'b0);
      check("reset_rdata", bus.rdata, 32'h0);
      check("reset_err", bus.err, 1'b0);
      check("reset_outstanding", outstanding, 3'd0);
      check("reset_rvalid3", bus3.rvalid, 1'b0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("idle_gnt", bus.gnt, 1'b0);
      @(posedge clk);
      #1;

      // vector table, back-to-back, latency 1
      for (int i = 0; i < 18; i++) begin
         issue(vecs[i].we, vecs[i].addr, vecs[i].be, vecs[i].wdata,
               vecs[i].rdata, vecs[i].err, 1'b1, 1'b1, 1'b0, acc);
      end
      drain();

      // FIFO full under response stall
      rsp_stall = 1'b1;
      issue(1'b0, 32'h100,  4'hF, '0, 32'hDEAD_BEAA, 1'b0, 1'b1, 1'b0, 1'b0, acc);
      issue(1'b0, 32'h200,  4'hF, '0, 32'hCA22_330D, 1'b0, 1'b1, 1'b0, 1'b1, acc);
      issue(1'b0, 32'h204,  4'hF, '0, 32'h5555_5555, 1'b0, 1'b1, 1'b0, 1'b1, acc);
      issue(1'b0, 32'h3FFC, 4'hF, '0, 32'h0BAD_CAFE, 1'b0, 1'b1, 1'b0, 1'b1, acc);
      bus.req = 1'b1; bus.we = 1'b0; bus.addr = 32'h100; bus.be = 4'hF;
      repeat (6) begin
         @(negedge clk);
         check("full_gnt", bus.gnt, 1'b0);
         check("full_outstanding", outstanding, 3'd4);
      end
      @(posedge clk);
      #1 rsp_stall = 1'b0;
      rel = cyc;
      issue(1'b0, 32'h100, 4'hF, '0, 32'hDEAD_BEAA, 1'b0, 1'b1, 1'b0, 1'b1, acc);
      check("fifth_accept_cycle", acc - rel, 2);
      drain();

      // grant stall then latency-3 load, on the second instance
      txn3(1'b1, 32'h10, 32'h1234_5678, 32'h0, 3);
      txn3(1'b0, 32'h10, 32'h0, 32'h1234_5678, 0);

      // asynchronous reset with responses in flight
      rsp_stall = 1'b1;
      issue(1'b0, 32'h100, 4'hF, '0, 32'hDEAD_BEAA, 1'b0, 1'b1, 1'b0, 1'b0, acc);
      issue(1'b0, 32'h200, 4'hF, '0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, acc);
      issue(1'b0, 32'h204, 4'hF, '0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, acc);
      @(negedge clk);
      check("pre_reset_outstanding", outstanding, 3'd3);
      @(posedge clk);
      #1 rsp_stall = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("pre_reset_rvalid", bus.rvalid, 1'b1);
      check("pre_reset_outstanding2", outstanding, 3'd2);
      #2 rst_n = 1'b0;
      #1;
      check("async_reset_rvalid", bus.rvalid, 1'b0);
      check("async_reset_outstanding", outstanding, 3'd0);
      wr_at_reset = rsp_wr;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      check("no_rsp_after_reset", rsp_wr - wr_at_reset, 0);
      issue(1'b0, 32'h100, 4'hF, '0, 32'hDEAD_BEAA, 1'b0, 1'b1, 1'b1, 1'b0, acc);
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
